// File: rtl/par_pkg.sv
// Shared types and constants for the parity/LRC frame checker.
package par_pkg;
  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;
endpackage

// File: rtl/par_word_chk.sv
// Single-beat parity check: ok when the XOR of data and parity equals the mode bit.
module par_word_chk #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par,
  input  logic              mode,
  output logic              ok
);
  assign ok = ((^{data, par}) == mode);
endmodule

// File: rtl/par_frame_checker.sv
// Receive-path checker: per-beat parity, sof/eof framing with LRC in the eof beat,
// and a saturating failed-frame counter. All outputs are registered (1-cycle latency).
module par_frame_checker
  import par_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              sof,
  input  logic              eof,
  input  logic              mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic              par_in,
  input  logic              clr_cnt,
  output logic              word_valid,
  output logic              parity_ok,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              proto_err,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int         LEN_W     = $clog2(MAX_LEN + 1);
  localparam bit         START_OVR = (MAX_LEN == 1);
  localparam [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t              state, state_nxt;
  logic                frame_mode, fm_nxt;
  logic [DATA_W-1:0]   lrc, lrc_nxt, lrc_fin;
  logic [LEN_W-1:0]    len, len_nxt, len_inc;
  logic                word_fail, wf_nxt;
  logic                active_mode, word_ok;
  logic                wv_nxt, po_nxt, fd_nxt, fo_nxt, pe_nxt, fail;

  // Non-sof beats inside a frame use the mode latched at sof.
  assign active_mode = (state == IN_FRAME && !sof) ? frame_mode : mode;
  assign lrc_fin     = lrc ^ data_in;
  assign len_inc     = len + LEN_W'(1);

  par_word_chk #(.DATA_W(DATA_W)) u_word_chk (
    .data (data_in),
    .par  (par_in),
    .mode (active_mode),
    .ok   (word_ok)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (valid) begin
      if (sof)
        state_nxt = (eof || START_OVR) ? IDLE : IN_FRAME;
      else if (state == IN_FRAME && (eof || len_inc == LEN_W'(MAX_LEN)))
        state_nxt = IDLE;
    end
  end

  always_comb begin
    wv_nxt  = valid;
    po_nxt  = valid & word_ok;
    fd_nxt  = 1'b0;
    fo_nxt  = 1'b0;
    pe_nxt  = 1'b0;
    fm_nxt  = frame_mode;
    lrc_nxt = lrc;
    len_nxt = len;
    wf_nxt  = word_fail;
    if (valid) begin
      if (sof) begin
        fm_nxt  = mode;
        lrc_nxt = data_in;
        len_nxt = LEN_W'(1);
        wf_nxt  = !word_ok;
        // A sof&eof beat that aborts a frame yields a single (failing) frame_done.
        if (state == IN_FRAME) begin
          pe_nxt = 1'b1;
          fd_nxt = 1'b1;
        end else if (eof) begin
          fd_nxt = 1'b1;
          fo_nxt = word_ok && (data_in == {DATA_W{mode}});
        end else if (START_OVR) begin
          pe_nxt = 1'b1;
          fd_nxt = 1'b1;
        end
      end else if (state == IDLE) begin
        pe_nxt = 1'b1;
      end else begin
        lrc_nxt = lrc_fin;
        len_nxt = len_inc;
        wf_nxt  = word_fail | !word_ok;
        if (eof) begin
          fd_nxt = 1'b1;
          fo_nxt = !word_fail && word_ok && (lrc_fin == {DATA_W{frame_mode}});
        end else if (len_inc == LEN_W'(MAX_LEN)) begin
          pe_nxt = 1'b1;
          fd_nxt = 1'b1;
        end
      end
    end
  end

  assign fail = fd_nxt & !fo_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_valid <= 1'b0;
      parity_ok  <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      proto_err  <= 1'b0;
      err_cnt    <= '0;
      frame_mode <= MODE_EVEN;
      lrc        <= '0;
      len        <= '0;
      word_fail  <= 1'b0;
    end else begin
      word_valid <= wv_nxt;
      parity_ok  <= po_nxt;
      frame_done <= fd_nxt;
      frame_ok   <= fo_nxt;
      proto_err  <= pe_nxt;
      frame_mode <= fm_nxt;
      lrc        <= lrc_nxt;
      len        <= len_nxt;
      word_fail  <= wf_nxt;
      if (clr_cnt)
        err_cnt <= fail ? CNT_W'(1) : '0;
      else if (fail && err_cnt != CNT_MAX)
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_par_frame_checker.sv
// Bench for par_frame_checker: directed vector table, reset corner cases, then
// random beats checked against a queue-based frame model.
module tb_par_frame_checker;
  localparam int DW = 8, ML = 4, CW = 2;

  logic clk = 1'b0, rst;
  logic valid, sof, eof, mode, par_in, clr_cnt;
  logic [DW-1:0] data_in;
  logic word_valid, parity_ok, frame_done, frame_ok, proto_err;
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  par_frame_checker #(.DATA_W(DW), .MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .valid(valid), .sof(sof), .eof(eof), .mode(mode),
    .data_in(data_in), .par_in(par_in), .clr_cnt(clr_cnt),
    .word_valid(word_valid), .parity_ok(parity_ok), .frame_done(frame_done),
    .frame_ok(frame_ok), .proto_err(proto_err), .err_cnt(err_cnt)
  );

  typedef struct {
    logic wv, po, fd, fo, pe;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    logic v, s, e, m;
    logic [DW-1:0] d;
    logic p, clr;
    exp_t x;
  } vec_t;

  int vectors = 0, miscompares = 0;

  // Frame model: beats of the open frame kept in a queue, judged as a whole.
  bit            m_in;
  bit            m_mode;
  bit            m_bad;
  logic [DW-1:0] m_q[$];
  int            m_cnt;

  function automatic logic [DW-1:0] fold_q();
    logic [DW-1:0] acc = '0;
    foreach (m_q[i]) acc ^= m_q[i];
    return acc;
  endfunction

  function automatic void model_reset();
    m_in = 0; m_mode = 0; m_bad = 0; m_q.delete(); m_cnt = 0;
  endfunction

  function automatic void model(input logic v, s, e, m, input logic [DW-1:0] d,
                                input logic p, clr, output exp_t x);
    bit am, aborted, fail;
    x = '{default: 1'b0};
    if (v) begin
      x.wv = 1;
      am = (m_in && !s) ? m_mode : m;
      x.po = (($countones({d, p}) % 2) == int'(am));
      if (s) begin
        aborted = m_in;
        if (aborted) begin x.pe = 1; x.fd = 1; end
        m_in = 0; m_mode = m; m_q = '{d}; m_bad = !x.po;
        if (e) begin
          if (!aborted) begin x.fd = 1; x.fo = x.po && (d == {DW{m}}); end
        end else if (m_q.size() == ML) begin
          x.pe = 1; x.fd = 1;
        end else m_in = 1;
      end else if (!m_in) begin
        x.pe = 1;
      end else begin
        m_q.push_back(d);
        m_bad = m_bad | !x.po;
        if (e) begin
          x.fd = 1; x.fo = !m_bad && (fold_q() == {DW{m_mode}}); m_in = 0;
        end else if (m_q.size() == ML) begin
          x.pe = 1; x.fd = 1; m_in = 0;
        end
      end
    end
    fail = x.fd && !x.fo;
    if (clr) m_cnt = fail ? 1 : 0;
    else if (fail && m_cnt < (1 << CW) - 1) m_cnt++;
    x.cnt = CW'(m_cnt);
  endfunction

  task automatic check(input string nm, input exp_t x);
    vectors++;
    if (word_valid !== x.wv) begin miscompares++; $display("FAIL %s word_valid got %b want %b", nm, word_valid, x.wv); end
    if (parity_ok !== x.po) begin miscompares++; $display("FAIL %s parity_ok got %b want %b", nm, parity_ok, x.po); end
    if (frame_done !== x.fd) begin miscompares++; $display("FAIL %s frame_done got %b want %b", nm, frame_done, x.fd); end
    if (frame_ok !== x.fo) begin miscompares++; $display("FAIL %s frame_ok got %b want %b", nm, frame_ok, x.fo); end
    if (proto_err !== x.pe) begin miscompares++; $display("FAIL %s proto_err got %b want %b", nm, proto_err, x.pe); end
    if (err_cnt !== x.cnt) begin miscompares++; $display("FAIL %s err_cnt got %0d want %0d", nm, err_cnt, x.cnt); end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic v, s, e, m, input logic [DW-1:0] d,
                      input logic p, clr, output exp_t x);
    valid = v; sof = s; eof = e; mode = m; data_in = d; par_in = p; clr_cnt = clr;
    model(v, s, e, m, d, p, clr, x);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, s, e, m, input logic [DW-1:0] d, input logic p, clr,
                              input logic wv, po, fd, fo, pe, input int cnt);
    vec_t t;
    t.v = v; t.s = s; t.e = e; t.m = m; t.d = d; t.p = p; t.clr = clr;
    t.x.wv = wv; t.x.po = po; t.x.fd = fd; t.x.fo = fo; t.x.pe = pe; t.x.cnt = CW'(cnt);
    return t;
  endfunction

  vec_t tbl[$];
  exp_t xm, zero;

  initial begin
    zero = '{default: 1'b0};
    //            v s e m  d      p clr   wv po fd fo pe cnt
    tbl.push_back(mk(1,1,1,0, 8'h00,0,0,  1,1,1,1,0, 0));
    tbl.push_back(mk(1,1,0,0, 8'h12,0,0,  1,1,0,0,0, 0));
    tbl.push_back(mk(1,0,0,0, 8'h34,1,0,  1,1,0,0,0, 0));
    tbl.push_back(mk(1,0,1,0, 8'h26,1,0,  1,1,1,1,0, 0));
    tbl.push_back(mk(1,1,0,1, 8'h12,1,0,  1,1,0,0,0, 0));
    tbl.push_back(mk(1,0,0,0, 8'h34,0,0,  1,1,0,0,0, 0));
    tbl.push_back(mk(1,0,1,0, 8'hD9,0,0,  1,1,1,1,0, 0));
    tbl.push_back(mk(1,1,0,0, 8'h12,0,0,  1,1,0,0,0, 0));
    tbl.push_back(mk(1,0,0,0, 8'h34,0,0,  1,0,0,0,0, 0));
    tbl.push_back(mk(1,0,1,0, 8'h26,1,0,  1,1,1,0,0, 1));
    tbl.push_back(mk(1,1,0,0, 8'h12,0,0,  1,1,0,0,0, 1));
    tbl.push_back(mk(1,0,0,0, 8'h34,1,0,  1,1,0,0,0, 1));
    tbl.push_back(mk(1,0,1,0, 8'h27,0,0,  1,1,1,0,0, 2));
    tbl.push_back(mk(1,1,0,0, 8'h01,1,0,  1,1,0,0,0, 2));
    tbl.push_back(mk(1,0,0,0, 8'h01,1,0,  1,1,0,0,0, 2));
    tbl.push_back(mk(1,0,0,0, 8'h01,1,0,  1,1,0,0,0, 2));
    tbl.push_back(mk(1,0,0,0, 8'h01,1,0,  1,1,1,0,1, 3));
    tbl.push_back(mk(1,0,0,0, 8'h00,0,0,  1,1,0,0,1, 3));
    tbl.push_back(mk(1,1,0,0, 8'h00,0,0,  1,1,0,0,0, 3));
    tbl.push_back(mk(1,1,0,0, 8'h00,0,0,  1,1,1,0,1, 3));
    tbl.push_back(mk(1,0,1,0, 8'h00,0,0,  1,1,1,1,0, 3));
    tbl.push_back(mk(0,0,0,0, 8'h00,0,1,  0,0,0,0,0, 0));
    tbl.push_back(mk(1,1,0,0, 8'h00,0,0,  1,1,0,0,0, 0));
    tbl.push_back(mk(1,0,1,0, 8'h01,1,1,  1,1,1,0,0, 1));
    tbl.push_back(mk(0,0,0,0, 8'h00,0,0,  0,0,0,0,0, 1));

    rst = 1'b0; valid = 0; sof = 0; eof = 0; mode = 0; data_in = '0; par_in = 0; clr_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset", zero);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].m, tbl[i].d, tbl[i].p, tbl[i].clr, xm);
      check($sformatf("tbl%0d", i), tbl[i].x);
    end

    // Async reset between edges mid-frame, then an orphan eof beat.
    step(1, 1, 0, 0, 8'h55, 0, 0, xm);
    check("pre_rst", xm);
    #2 rst = 1'b0;
    #1 check("async_rst", zero);
    model_reset();
    @(negedge clk) rst = 1'b1;
    step(1, 0, 1, 0, 8'h00, 0, 0, xm);
    check("orphan_eof", '{wv: 1'b1, po: 1'b1, fd: 1'b0, fo: 1'b0, pe: 1'b1, cnt: '0});

    for (int i = 0; i < 600; i++) begin
      logic v, s, e, m, p, clr, am;
      logic [DW-1:0] d;
      v = ($urandom_range(99) < 85);
      s = ($urandom_range(99) < 20);
      e = ($urandom_range(99) < 25);
      m = 1'($urandom);
      d = DW'($urandom);
      clr = ($urandom_range(99) < 3);
      am = (m_in && !s) ? m_mode : m;
      if (e && $urandom_range(1)) d = s ? {DW{m}} : (fold_q() ^ {DW{m_mode}});
      p = ^d ^ am;
      if ($urandom_range(99) < 10) p = ~p;
      step(v, s, e, m, d, p, clr, xm);
      check($sformatf("rnd%0d", i), xm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
